// File: rtl/lsu_writeback.sv
// Multi-cycle load/store unit feeding the register file write port (AD3/WE3/WD3).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests raise err instead of truncating.
module lsu_writeback #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_ad3,
  output logic [WIDTH-1:0] wb_wd3,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addrLo;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_count;

  logic             w_legal;
  logic             w_misalign;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_loadData;
  logic             w_timeout;

  assign req_ready = (r_state == IDLE);

  always_comb begin
    w_legal = 1'b0;
    if (req_we) begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Store lane steering; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {req_addr[1], 1'b0};
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addrLo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addrLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'b0, w_byte};
      3'b101:  w_loadData = {16'b0, w_half};
      default: w_loadData = mem_rdata;
    endcase
    w_timeout = (TIMEOUT != 0) && (r_count == CW'(TLIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b0;
      r_addrLo  <= 2'b0;
      r_rd      <= 5'b0;
      r_count   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_we     <= 1'b0;
      wb_ad3    <= 5'b0;
      wb_wd3    <= '0;
      err       <= 1'b0;
    end else begin
      err   <= 1'b0;
      wb_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (!w_legal || w_misalign) begin
              err <= 1'b1;
            end else begin
              r_we      <= req_we;
              r_funct3  <= req_funct3;
              r_addrLo  <= req_addr[1:0];
              r_rd      <= req_rd;
              r_count   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= w_be;
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= w_wdata;
              r_state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (r_we) begin
              r_state <= IDLE;
            end else begin
              wb_we   <= (r_rd != 5'd0);
              wb_ad3  <= r_rd;
              wb_wd3  <= w_loadData;
              r_state <= WB;
            end
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        WB: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Multi-cycle load/store unit that sits directly upstream of the register file's write port (AD3/WE3/WD3).
- Accepts one memory request at a time from the execute stage and sequences it through a single-ported data memory that may insert wait states.
- Aligns store data and byte enables; extracts and sign/zero-extends load data.
- For loads, produces a one-cycle registered writeback pulse that the register file captures on the following falling edge.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, maximum cycles spent in ACCESS without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  WIDTH  effective byte address.
- req_wdata  in  WIDTH  store data (rs2).
- req_rd  in  5  load destination register.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  WIDTH  word address {addr[31:2],2'b00}.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  WIDTH  read data.
- wb_we  out  1  register-file write enable (drives WE3).
- wb_ad3  out  5  destination register (drives AD3).
- wb_wd3  out  WIDTH  write data (drives WD3).
- err  out  1  one-cycle pulse: illegal funct3, timeout, or misalignment (with the optional feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_we, wb_ad3, wb_wd3, err all 0; req_ready 1 once rst_n is released.
- Reset asserted mid-operation: access abandoned, no writeback, no err.
- States: IDLE, ACCESS, WB. All outputs are registered except req_ready = (state == IDLE).
- IDLE:
  - On req_valid & req_ready, capture all req_* fields.
  - Legal funct3: go to ACCESS and assert mem_req with fields from the next cycle.
  - Illegal funct3 (load 011/110/111, store 011–111): no memory access; err pulses for one cycle; stay IDLE.
- ACCESS:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata are held stable until the cycle mem_ack = 1.
  - mem_ack may arrive in the first ACCESS cycle.
  - On ack of a store: go to IDLE; mem_req drops the next cycle.
  - On ack of a load: latch extracted data and go to WB.
- WB: wb_we = 1 for exactly one cycle, with wb_ad3 = rd and wb_wd3 = data; then go to IDLE. wb_we is suppressed when rd == 0, but state still passes through WB.
- Latency:
  - Request accepted at cycle N; mem_req high at N+1.
  - Ack at cycle M ≥ N+1; load wb_we high at M+1; req_ready high again at M+2 for loads, M+1 for stores.
- Timeout:
  - Wait counter clears on entry to ACCESS and increments each non-ack cycle.
  - When it reaches TIMEOUT: drop mem_req, pulse err, go to IDLE, no writeback.
  - An ack in the same cycle as the limit wins (normal completion).
- Store lane rules:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = 0011 << {addr[1],1'b0}; wdata = half replicated ×2.
  - SW: be = 1111; wdata = req_wdata.
- Load extraction:
  - LB/LBU: byte at mem_rdata[8*addr[1:0] +: 8], sign-/zero-extended.
  - LH/LHU: half at mem_rdata[16*addr[1] +: 16], sign-/zero-extended.
  - LW: full word.
  - Loads drive mem_be = 1111, mem_we = 0.
- Misaligned accesses without the optional feature: low address bits below access size are ignored (LH/SH ignore addr[0]; LW/SW ignore addr[1:0]).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned halfword (addr[0] = 1) or word (addr[1:0] ≠ 0) requests are accepted but perform no memory access.
  - err pulses on the cycle after acceptance; state returns to IDLE; no writeback.
- Undefined: misaligned accesses are truncated as described in Behaviour; err is never raised for alignment.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, ack after 3 wait cycles -> mem_be = 1111, mem_addr = 0x104, mem_req high for exactly 4 cycles, no wb_we.
- SB addr 0x203, data 0x000000A5, immediate ack -> mem_be = 1000, mem_addr = 0x200, mem_wdata = 0xA5A5A5A5.
- LB addr 0x102, rd = 5, mem_rdata = 0x12_80_34_56 -> wb_we pulse one cycle after ack, wb_ad3 = 5, wb_wd3 = 0xFFFFFF80; the same access as LBU -> 0x00000080.
- LH addr 0x102, rd = 0, mem_rdata = 0x8001_0000 -> mem_req/ack occur, wb_we stays 0, req_ready returns 2 cycles after ack.
- Load with no ack, TIMEOUT = 16 -> mem_req drops after 16 ACCESS cycles, err pulse, no wb_we, next request accepted.
- rst_n low during ACCESS, then a LW with illegal funct3 011 -> outputs immediately 0; illegal request gives err pulse and no mem_req. With LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> err, no mem_req.
